// File: rtl/seg_ctrl_if.sv
// Segment-register load handshake bundle: CS/sreg load requesters, prefix decode,
// segment select and the write port of the segment register bank.
interface seg_ctrl_if;
    // Interrupt-vector CS load
    logic        int_req;
    logic [15:0] int_cs;
    logic        int_ack;
    // Far JMP/CALL/RET CS load
    logic        far_req;
    logic [15:0] far_cs;
    logic        far_ack;
    // Execution-unit MOV/POP sreg
    logic        eu_req;
    logic [1:0]  eu_sel;
    logic [15:0] eu_data;
    logic        eu_ack;
    logic        eu_err;
    // Prefix decode and access-segment selection
    logic        pfx_load;
    logic [1:0]  pfx_sel;
    logic        instr_end;
    logic [1:0]  acc_type;
    logic [1:0]  seg_sel;
    // Segment register bank write port
    logic        ena_cs;
    logic        ena_ds;
    logic        ena_es;
    logic        ena_ss;
    logic [15:0] d_seg;
    logic        busy;
    logic        int_inhibit;

    modport slave (
        input  int_req, int_cs, far_req, far_cs, eu_req, eu_sel, eu_data,
        input  pfx_load, pfx_sel, instr_end, acc_type,
        output int_ack, far_ack, eu_ack, eu_err, seg_sel,
        output ena_cs, ena_ds, ena_es, ena_ss, d_seg, busy, int_inhibit
    );

    modport master (
        output int_req, int_cs, far_req, far_cs, eu_req, eu_sel, eu_data,
        output pfx_load, pfx_sel, instr_end, acc_type,
        input  int_ack, far_ack, eu_ack, eu_err, seg_sel,
        input  ena_cs, ena_ds, ena_es, ena_ss, d_seg, busy, int_inhibit
    );
endinterface

// File: rtl/seg_ctrl.sv
// Segment register controller: arbitrates CS/sreg loads into the segment bank,
// tracks the segment-override prefix and the post-SS-load interrupt inhibit.
module seg_ctrl #(
    parameter bit INHIBIT_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    seg_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StAck   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        WinInt = 2'd0,
        WinFar = 2'd1,
        WinEu  = 2'd2
    } win_e;

    localparam logic [1:0] SegEs = 2'b00;
    localparam logic [1:0] SegCs = 2'b01;
    localparam logic [1:0] SegSs = 2'b10;
    localparam logic [1:0] SegDs = 2'b11;

    state_e      state_q;
    win_e        win_q;
    logic        ena_cs_q;
    logic        ena_ds_q;
    logic        ena_es_q;
    logic        ena_ss_q;
    logic [15:0] d_seg_q;
    logic        int_ack_q;
    logic        far_ack_q;
    logic        eu_ack_q;
    logic        eu_err_q;
    logic        busy_q;
    logic        inhibit_q;
    logic [1:0]  pfx_q;
    logic        pfx_vld_q;

    logic        arb_any;
    logic        arb_err;
    win_e        arb_win;
    logic [1:0]  arb_tgt;
    logic [15:0] arb_data;

    // Fixed priority INT > FAR > EU; INT and FAR always load CS.
    always_comb begin
        arb_any  = bus.int_req | bus.far_req | bus.eu_req;
        arb_win  = WinEu;
        arb_tgt  = bus.eu_sel;
        arb_data = bus.eu_data;
        if (bus.int_req) begin
            arb_win  = WinInt;
            arb_tgt  = SegCs;
            arb_data = bus.int_cs;
        end else if (bus.far_req) begin
            arb_win  = WinFar;
            arb_tgt  = SegCs;
            arb_data = bus.far_cs;
        end
        // MOV/POP into CS is illegal: acknowledged with an error, bank untouched.
        arb_err = (arb_win == WinEu) && (arb_tgt == SegCs);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            win_q     <= WinInt;
            ena_cs_q  <= 1'b0;
            ena_ds_q  <= 1'b0;
            ena_es_q  <= 1'b0;
            ena_ss_q  <= 1'b0;
            d_seg_q   <= 16'h0000;
            int_ack_q <= 1'b0;
            far_ack_q <= 1'b0;
            eu_ack_q  <= 1'b0;
            eu_err_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ena_cs_q  <= 1'b0;
            ena_ds_q  <= 1'b0;
            ena_es_q  <= 1'b0;
            ena_ss_q  <= 1'b0;
            d_seg_q   <= 16'h0000;
            int_ack_q <= 1'b0;
            far_ack_q <= 1'b0;
            eu_ack_q  <= 1'b0;
            eu_err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        win_q  <= arb_win;
                        busy_q <= 1'b1;
                        if (arb_err) begin
                            state_q  <= StAck;
                            eu_ack_q <= 1'b1;
                            eu_err_q <= 1'b1;
                        end else begin
                            state_q  <= StGrant;
                            d_seg_q  <= arb_data;
                            ena_cs_q <= (arb_tgt == SegCs);
                            ena_ds_q <= (arb_tgt == SegDs);
                            ena_es_q <= (arb_tgt == SegEs);
                            ena_ss_q <= (arb_tgt == SegSs);
                        end
                    end
                end
                StGrant: begin
                    state_q   <= StAck;
                    int_ack_q <= (win_q == WinInt);
                    far_ack_q <= (win_q == WinFar);
                    eu_ack_q  <= (win_q == WinEu);
                end
                StAck: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // An SS load blocks interrupts until the following instruction has ended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inhibit_q <= 1'b0;
        end else if (INHIBIT_EN && (state_q == StGrant) && ena_ss_q) begin
            inhibit_q <= 1'b1;
        end else if (bus.instr_end) begin
            inhibit_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pfx_q     <= SegDs;
            pfx_vld_q <= 1'b0;
        end else if (bus.pfx_load) begin
            pfx_q     <= bus.pfx_sel;
            pfx_vld_q <= 1'b1;
        end else if (bus.instr_end) begin
            pfx_vld_q <= 1'b0;
        end
    end

    // Code fetch and string destination ignore any override.
    always_comb begin
        case (bus.acc_type)
            2'b00:   bus.seg_sel = SegCs;
            2'b01:   bus.seg_sel = pfx_vld_q ? pfx_q : SegDs;
            2'b10:   bus.seg_sel = pfx_vld_q ? pfx_q : SegSs;
            default: bus.seg_sel = SegEs;
        endcase
    end

    assign bus.ena_cs      = ena_cs_q;
    assign bus.ena_ds      = ena_ds_q;
    assign bus.ena_es      = ena_es_q;
    assign bus.ena_ss      = ena_ss_q;
    assign bus.d_seg       = d_seg_q;
    assign bus.int_ack     = int_ack_q;
    assign bus.far_ack     = far_ack_q;
    assign bus.eu_ack      = eu_ack_q;
    assign bus.eu_err      = eu_err_q;
    assign bus.busy        = busy_q;
    assign bus.int_inhibit = inhibit_q;

`ifndef SYNTHESIS
    a_ena_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({ena_cs_q, ena_ds_q, ena_es_q, ena_ss_q}));
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({int_ack_q, far_ack_q, eu_ack_q}));
`endif

endmodule

// File: tb/tb_seg_ctrl.sv
// Scoreboard bench for seg_ctrl: directed loads, arbitration, prefix override,
// interrupt inhibit and reset abort, checked against hand-computed values.
module tb_seg_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_ctrl_if bus ();
    seg_ctrl_if bus0 ();

    seg_ctrl #(.INHIBIT_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    seg_ctrl #(.INHIBIT_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    assign bus0.int_req   = bus.int_req;
    assign bus0.int_cs    = bus.int_cs;
    assign bus0.far_req   = bus.far_req;
    assign bus0.far_cs    = bus.far_cs;
    assign bus0.eu_req    = bus.eu_req;
    assign bus0.eu_sel    = bus.eu_sel;
    assign bus0.eu_data   = bus.eu_data;
    assign bus0.pfx_load  = bus.pfx_load;
    assign bus0.pfx_sel   = bus.pfx_sel;
    assign bus0.instr_end = bus.instr_end;
    assign bus0.acc_type  = bus.acc_type;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Segment register bank driven by the DUT write port.
    logic [15:0] q_cs, q_ds, q_es, q_ss;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_cs <= 16'hF000;
            q_ds <= 16'h0000;
            q_es <= 16'h0000;
            q_ss <= 16'h0000;
        end else begin
            if (bus.ena_cs) q_cs <= bus.d_seg;
            if (bus.ena_ds) q_ds <= bus.d_seg;
            if (bus.ena_es) q_es <= bus.d_seg;
            if (bus.ena_ss) q_ss <= bus.d_seg;
        end
    end

    // ack = {int,far,eu}; ena/tgt = {cs,ds,es,ss}; tg/ta = expected cycle, 0 = unchecked
    typedef struct packed {
        logic [2:0]  ack;
        logic        err;
        logic [3:0]  ena;
        logic [3:0]  tgt;
        logic [15:0] data;
        int          tg;
        int          ta;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bank_of(input logic [3:0] tgt);
        case (tgt)
            4'b1000: return q_cs;
            4'b0100: return q_ds;
            4'b0010: return q_es;
            default: return q_ss;
        endcase
    endfunction

    task automatic push(input logic [2:0] ack, input logic err, input logic [3:0] ena,
                        input logic [3:0] tgt, input logic [15:0] data, input int tg,
                        input int ta);
        exp_t e;
        e.ack = ack; e.err = err; e.ena = ena; e.tgt = tgt; e.data = data; e.tg = tg; e.ta = ta;
        sbq.push_back(e);
    endtask

    // Monitor: compares grants against the head entry, pops on each acknowledge.
    always @(negedge clk) begin
        logic [3:0] ena_now;
        logic [2:0] ack_now;
        exp_t       e;
        ena_now = {bus.ena_cs, bus.ena_ds, bus.ena_es, bus.ena_ss};
        ack_now = {bus.int_ack, bus.far_ack, bus.eu_ack};
        if (rst) begin
            if (ena_now != 4'b0000) begin
                if (sbq.size() == 0) begin
                    check("unexpected_grant", {28'h0, ena_now}, 32'h0);
                end else begin
                    e = sbq[0];
                    check("grant_ena", {28'h0, ena_now}, {28'h0, e.ena});
                    check("grant_data", {16'h0, bus.d_seg}, {16'h0, e.data});
                    if (e.tg != 0) check("grant_cycle", cyc, e.tg);
                end
            end else begin
                check("d_seg_idle_zero", {16'h0, bus.d_seg}, 32'h0);
            end
            if (ack_now != 3'b000) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", {29'h0, ack_now}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    check("ack_kind", {29'h0, ack_now}, {29'h0, e.ack});
                    check("ack_err", {31'h0, bus.eu_err}, {31'h0, e.err});
                    check("bank_value", {16'h0, bank_of(e.tgt)}, {16'h0, e.data});
                    if (e.ta != 0) check("ack_cycle", cyc, e.ta);
                end
            end
        end
    end

    // Requester side: drop each request once acknowledged, bounded wait.
    task automatic run_txns(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            if (bus.int_ack) bus.int_req = 1'b0;
            if (bus.far_ack) bus.far_req = 1'b0;
            if (bus.eu_ack)  bus.eu_req  = 1'b0;
            n++;
        end
        if (sbq.size() != 0) begin
            check("txn_timeout", sbq.size(), 0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_sel(input logic [1:0] acc, input logic [1:0] exp, input string name);
        bus.acc_type = acc;
        #1;
        check(name, {30'h0, bus.seg_sel}, {30'h0, exp});
    endtask

    task automatic pulse_instr_end();
        @(negedge clk) bus.instr_end = 1'b1;
        @(negedge clk) bus.instr_end = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.int_req = 0; bus.int_cs = 0; bus.far_req = 0; bus.far_cs = 0;
        bus.eu_req = 0; bus.eu_sel = 0; bus.eu_data = 0;
        bus.pfx_load = 0; bus.pfx_sel = 0; bus.instr_end = 0; bus.acc_type = 2'b01;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_ena", {28'h0, bus.ena_cs, bus.ena_ds, bus.ena_es, bus.ena_ss}, 32'h0);
        check("rst_d_seg", {16'h0, bus.d_seg}, 32'h0);
        check("rst_acks", {28'h0, bus.int_ack, bus.far_ack, bus.eu_ack, bus.eu_err}, 32'h0);
        check("rst_inhibit", {31'h0, bus.int_inhibit}, 32'h0);
        chk_sel(2'b01, 2'b11, "rst_sel_data");
        chk_sel(2'b00, 2'b01, "rst_sel_code");
        chk_sel(2'b11, 2'b00, "rst_sel_str");
        repeat (2) @(negedge clk);

        // EU load into CS right at reset release: error, no write, 2 cycles
        rst = 1'b1;
        c = cyc;
        bus.eu_req = 1; bus.eu_sel = 2'b01; bus.eu_data = 16'h1111;
        push(3'b001, 1'b1, 4'b0000, 4'b1000, 16'hF000, 0, c + 1);
        run_txns(10);

        // MOV DS
        c = cyc;
        bus.eu_req = 1; bus.eu_sel = 2'b11; bus.eu_data = 16'h5678;
        push(3'b001, 1'b0, 4'b0100, 4'b0100, 16'h5678, c + 1, c + 2);
        run_txns(10);

        // Three simultaneous requesters, served INT, FAR, EU
        c = cyc;
        bus.int_req = 1; bus.int_cs = 16'h1234;
        bus.far_req = 1; bus.far_cs = 16'hABCD;
        bus.eu_req = 1; bus.eu_sel = 2'b10; bus.eu_data = 16'h9ABC;
        push(3'b100, 1'b0, 4'b1000, 4'b1000, 16'h1234, c + 1, c + 2);
        push(3'b010, 1'b0, 4'b1000, 4'b1000, 16'hABCD, c + 4, c + 5);
        push(3'b001, 1'b0, 4'b0001, 4'b0001, 16'h9ABC, c + 7, c + 8);
        run_txns(20);
        check("arb_inhibit_set", {31'h0, bus.int_inhibit}, 32'h1);
        pulse_instr_end();
        check("arb_inhibit_clr", {31'h0, bus.int_inhibit}, 32'h0);

        // Segment override prefix
        @(negedge clk) begin bus.pfx_load = 1; bus.pfx_sel = 2'b00; end
        @(negedge clk) bus.pfx_load = 0;
        chk_sel(2'b01, 2'b00, "pfx_data_es");
        chk_sel(2'b00, 2'b01, "pfx_code_cs");
        chk_sel(2'b10, 2'b00, "pfx_stack_es");
        pulse_instr_end();
        chk_sel(2'b01, 2'b11, "pfx_cleared_ds");
        chk_sel(2'b10, 2'b10, "pfx_cleared_ss");
        @(negedge clk) begin bus.pfx_load = 1; bus.pfx_sel = 2'b10; bus.instr_end = 1; end
        @(negedge clk) begin bus.pfx_load = 0; bus.instr_end = 0; end
        chk_sel(2'b01, 2'b10, "pfx_load_wins");
        @(negedge clk) begin bus.pfx_load = 1; bus.pfx_sel = 2'b00; end
        @(negedge clk) bus.pfx_sel = 2'b01;
        @(negedge clk) bus.pfx_load = 0;
        chk_sel(2'b01, 2'b01, "pfx_last_wins");
        pulse_instr_end();
        chk_sel(2'b01, 2'b11, "pfx_final_clr");

        // SS load: inhibit from ACK until the cycle after INSTR_END
        @(negedge clk);
        c = cyc;
        bus.eu_req = 1; bus.eu_sel = 2'b10; bus.eu_data = 16'hDEF0;
        push(3'b001, 1'b0, 4'b0001, 4'b0001, 16'hDEF0, c + 1, c + 2);
        @(negedge clk) check("inh_in_grant", {31'h0, bus.int_inhibit}, 32'h0);
        @(negedge clk) begin
            check("inh_at_ack", {31'h0, bus.int_inhibit}, 32'h1);
            check("inh_disabled", {31'h0, bus0.int_inhibit}, 32'h0);
            bus.eu_req = 0;
        end
        @(negedge clk) begin
            check("inh_hold", {31'h0, bus.int_inhibit}, 32'h1);
            bus.instr_end = 1;
        end
        @(negedge clk) begin
            check("inh_cleared", {31'h0, bus.int_inhibit}, 32'h0);
            bus.instr_end = 0;
        end

        // SS write and INSTR_END on the same edge: set wins
        @(negedge clk);
        c = cyc;
        bus.eu_req = 1; bus.eu_sel = 2'b10; bus.eu_data = 16'h0F0F;
        push(3'b001, 1'b0, 4'b0001, 4'b0001, 16'h0F0F, c + 1, c + 2);
        @(negedge clk) bus.instr_end = 1;
        @(negedge clk) begin
            bus.instr_end = 0;
            bus.eu_req = 0;
            check("inh_set_wins", {31'h0, bus.int_inhibit}, 32'h1);
        end
        @(negedge clk) check("inh_set_hold", {31'h0, bus.int_inhibit}, 32'h1);
        pulse_instr_end();
        check("inh_set_clr", {31'h0, bus.int_inhibit}, 32'h0);

        // Reset during GRANT of a far CS load
        c = cyc;
        bus.far_req = 1; bus.far_cs = 16'h4321;
        push(3'b010, 1'b0, 4'b1000, 4'b1000, 16'h4321, 0, 0);
        @(negedge clk) check("rst_abort_grant", {31'h0, bus.ena_cs}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rst_abort_ena", {31'h0, bus.ena_cs}, 32'h0);
        check("rst_abort_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_abort_ack", {31'h0, bus.far_ack}, 32'h0);
        @(negedge clk) begin
            check("rst_abort_noack", {31'h0, bus.far_ack}, 32'h0);
            rst = 1'b1;
        end
        run_txns(10);
        check("rst_abort_cs", {16'h0, q_cs}, 32'h4321);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_ctrl.md
SEG_CTRL -- requirements
Module: seg_ctrl

Interface
REQ-001 The block SHALL have parameter INHIBIT_EN, default 1, meaning that when it is 1 an SS load sets INT_INHIBIT.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have ports INT_REQ (input, 1), INT_CS (input, 16) and INT_ACK (output, 1): the interrupt-vector CS load requester.
REQ-005 The block SHALL have ports FAR_REQ (input, 1), FAR_CS (input, 16) and FAR_ACK (output, 1): the far JMP/CALL/RET CS load requester.
REQ-006 The block SHALL have ports EU_REQ (input, 1), EU_SEL (input, 2), EU_DATA (input, 16), EU_ACK (output, 1) and EU_ERR (output, 1): the execution-unit MOV/POP sreg requester.
REQ-007 The block SHALL use the segment encoding 00=ES, 01=CS, 10=SS, 11=DS.
REQ-008 The block SHALL have ports PFX_LOAD (input, 1) and PFX_SEL (input, 2): the segment-override prefix decode.
REQ-009 The block SHALL have port INSTR_END (input, 1): a one-cycle pulse marking the end of an instruction.
REQ-010 The block SHALL have ports ACC_TYPE (input, 2) and SEG_SEL (output, 2): the bus access type (00 code, 01 data, 10 stack, 11 string destination) and the selected segment.
REQ-011 The block SHALL have outputs ENA_CS, ENA_DS, ENA_ES and ENA_SS (1 bit each) and D_SEG (16 bits): the write enables and shared write data for the segment register bank.
REQ-012 The block SHALL have outputs BUSY (1) and INT_INHIBIT (1).

Function
REQ-013 The FSM SHALL have three states, IDLE, GRANT and ACK, and SHALL advance IDLE->GRANT->ACK->IDLE unconditionally after arbitration.
REQ-014 In IDLE, with any request asserted, the block SHALL register the winner, target and data, and enter GRANT on the next edge.
REQ-015 The arbitration priority SHALL be fixed: INT > FAR > EU; losers keep their request high and are re-arbitrated on return to IDLE.
REQ-016 In GRANT, exactly one ENA_xx SHALL be high for one cycle, and D_SEG SHALL equal the registered data.
REQ-017 INT and FAR requests SHALL always target CS.
REQ-018 In ACK, exactly one of INT_ACK, FAR_ACK or EU_ACK SHALL pulse high for one cycle, and the bank SHALL already hold the new value.
REQ-019 An EU request with EU_SEL=01 (CS) SHALL go IDLE->ACK with no ENA asserted, with EU_ACK and EU_ERR both pulsing that cycle.
REQ-020 Requesters SHALL hold REQ and data stable until ACK; REQ deasserted before ACK is a protocol error and leaves the outcome undefined.
REQ-021 Request inputs SHALL be ignored in GRANT and ACK.
REQ-022 BUSY SHALL be high in GRANT and ACK.
REQ-023 D_SEG SHALL be 0 outside GRANT.
REQ-024 PFX_LOAD SHALL latch PFX_SEL into an override register and set its valid flag; INSTR_END SHALL clear the valid flag.
REQ-025 If PFX_LOAD and INSTR_END occur in the same cycle, PFX_LOAD SHALL win and valid SHALL be 1.
REQ-026 A second PFX_LOAD before INSTR_END SHALL overwrite the first (the last prefix wins).
REQ-027 SEG_SEL SHALL be combinational: ACC_TYPE 00 -> CS and 11 -> ES always; 01 -> DS and 10 -> SS unless the override is valid, in which case SEG_SEL equals the override.
REQ-028 When INHIBIT_EN=1, INT_INHIBIT SHALL be set on the edge ending a GRANT that writes SS, and cleared by the next INSTR_END.
REQ-029 If an SS write and INSTR_END occur in the same cycle, the SS set SHALL win.

Reset
REQ-030 While RST=0, asynchronously: state SHALL be IDLE; ENA_xx, all ACKs, EU_ERR, BUSY and INT_INHIBIT SHALL be 0; D_SEG SHALL be 0; the override SHALL be invalid.
REQ-031 Reset asserted mid-GRANT SHALL drop ENA immediately, and no ACK SHALL be issued for the aborted request.
REQ-032 The first arbitration SHALL occur on the first rising edge with RST=1.

Verification
REQ-033 Scenario: EU_REQ=1, EU_SEL=11, EU_DATA=5678 from IDLE -> ENA_DS=1 and D_SEG=5678 at cycle+1; EU_ACK=1 at cycle+2; bank Q_DS=5678.
REQ-034 Scenario: INT_REQ (INT_CS=1234), FAR_REQ (FAR_CS=ABCD) and EU_REQ (SS, 9ABC) asserted together -> CS=1234 with INT_ACK, then CS=ABCD with FAR_ACK, then SS=9ABC with EU_ACK, 3 cycles each.
REQ-035 Scenario: EU_REQ with EU_SEL=01 -> no ENA; EU_ACK=EU_ERR=1 at cycle+1; Q_CS unchanged (F000 after reset).
REQ-036 Scenario: PFX_LOAD with PFX_SEL=00, then ACC_TYPE=01 -> SEG_SEL=00; ACC_TYPE=00 -> SEG_SEL=01; after INSTR_END, ACC_TYPE=01 -> SEG_SEL=11.
REQ-037 Scenario: EU write of SS=DEF0 -> INT_INHIBIT=1 from the ACK cycle until the cycle after INSTR_END, when it reads 0; with INHIBIT_EN=0 it stays 0.
REQ-038 Scenario: RST=0 pulsed during GRANT of FAR_REQ -> ENA_CS falls asynchronously, no FAR_ACK; after release with FAR_REQ still high, a full 3-cycle write completes.
